uart_tx_slave: RTL and testbench

Memory-mapped UART transmitter that sits on the core's slave-port bus as a responder, alongside the ROM and RAM slaves. It takes word-addressed register writes and reads from the core. Written bytes are queued in a small FIFO and serialised onto `txd` as 8N1 frames at a programmable bit period.

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_slave.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_slave.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register offsets (word index taken from s_addr[3:2])
//   - STATUS and CTRL bit positions
//   - transmit FSM state type
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_IE  = 1;
    localparam int unsigned CTRL_PEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk    - rising-edge clock
//   flush  - synchronous clear of pointers and count
//   push   - write din; accepted when not full, or when full with a same-cycle pop
//   pop    - advance read pointer (ignored when empty)
//   din    - byte to write
//   dout   - byte at the head (combinational read)
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - number of stored bytes
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter on the slave-port bus.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   s_ce, s_we   - access strobe and write select
//   s_addr       - byte address, s_addr[3:2] selects TXDATA/STATUS/BAUDDIV/CTRL
//   s_addr_sel   - byte enables for writes
//   s_wdata      - write data
//   s_rdata      - registered read data (1-cycle latency, holds otherwise)
//   txd          - serial output, idles high
//   irq          - high while FIFO empty and CTRL.ie set
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, gated by CTRL.pen).
module uart_tx_slave
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_ce,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [3:0]  s_addr_sel,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          wr_en;
    logic          rd_en;
    logic          push_req;
    logic          ovf_set;
    logic          ovf_clr;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0]   baud;
    logic [15:0]   div_eff;
    logic          ctrl_en;
    logic          ctrl_ie;
    logic          ctrl_pen;
    logic          overflow;
    logic [31:0]   rd_word;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   div_q, div_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    data, data_n;
    logic          txd_n;
    logic          start_ok;
    logic          bit_end;

    logic          unused_bits;
    assign unused_bits = ^{s_addr[31:4], s_addr[1:0], s_addr_sel[3:2],
                           s_wdata[31:16], s_wdata[CTRL_PEN]};

    assign reg_sel  = s_addr[3:2];
    assign wr_en    = s_ce & s_we;
    assign rd_en    = s_ce & ~s_we;
    assign push_req = wr_en && (reg_sel == REG_TXDATA) && s_addr_sel[0];
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = wr_en && (reg_sel == REG_STATUS) && s_addr_sel[0] && s_wdata[ST_OVF];
    assign div_eff  = (baud == '0) ? 16'd1 : baud;
    assign irq      = fifo_empty & ctrl_ie;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .flush (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (s_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_pen <= 1'b0;
        end else if (wr_en && (reg_sel == REG_CTRL) && s_addr_sel[0]) begin
            ctrl_pen <= s_wdata[CTRL_PEN];
        end
    end
`else
    assign ctrl_pen = 1'b0;
`endif

    // Register file and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            baud     <= DEFAULT_DIV;
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            overflow <= 1'b0;
            s_rdata  <= '0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (wr_en && (reg_sel == REG_BAUDDIV)) begin
                if (s_addr_sel[0]) baud[7:0]  <= s_wdata[7:0];
                if (s_addr_sel[1]) baud[15:8] <= s_wdata[15:8];
            end
            if (wr_en && (reg_sel == REG_CTRL) && s_addr_sel[0]) begin
                ctrl_en <= s_wdata[CTRL_EN];
                ctrl_ie <= s_wdata[CTRL_IE];
            end
            if (rd_en) begin
                s_rdata <= rd_word;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_word[ST_BUSY]             = (state != S_IDLE);
                rd_word[ST_FULL]             = fifo_full;
                rd_word[ST_EMPTY]            = fifo_empty;
                rd_word[ST_OVF]              = overflow;
                rd_word[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
            end
            REG_BAUDDIV: rd_word[15:0] = baud;
            REG_CTRL: begin
                rd_word[CTRL_EN]  = ctrl_en;
                rd_word[CTRL_IE]  = ctrl_ie;
                rd_word[CTRL_PEN] = ctrl_pen;
            end
            default: rd_word = '0;
        endcase
    end

    // Transmit FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            div_q <= DEFAULT_DIV;
            idx   <= '0;
            data  <= '0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            div_q <= div_n;
            idx   <= idx_n;
            data  <= data_n;
            txd   <= txd_n;
        end
    end

    // Next state. A frame may start from IDLE or directly from the last STOP
    // cycle, which gives gapless back-to-back frames. txd is registered from
    // the next state so the line never glitches.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        div_n    = div_q;
        idx_n    = idx;
        data_n   = data;
        pop      = 1'b0;
        start_ok = ctrl_en && !fifo_empty;
        bit_end  = (cnt == 16'd1);

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    state_n = S_START;
                    data_n  = fifo_dout;
                    div_n   = div_eff;
                    cnt_n   = div_eff;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    cnt_n   = div_q;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n = div_q;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = ctrl_pen ? S_PARITY : S_STOP;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cnt_n   = div_q;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        state_n = S_START;
                        data_n  = fifo_dout;
                        div_n   = div_eff;
                        cnt_n   = div_eff;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = data_n[idx_n];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_n = ^data_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: self-checking bench for uart_tx_slave.
// Serial output is compared cycle by cycle against a frame model that maps a
// cycle offset to the expected line level from byte, bit period and parity.
module tb_uart_tx_slave;

    localparam logic [1:0] A_TX   = 2'd0;
    localparam logic [1:0] A_ST   = 2'd1;
    localparam logic [1:0] A_BAUD = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_ce = 1'b0;
    logic        s_we = 1'b0;
    logic [31:0] s_addr = '0;
    logic [3:0]  s_addr_sel = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_rdata;
    logic        txd;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_slave #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_ce       (s_ce),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_addr_sel (s_addr_sel),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .txd        (txd),
        .irq        (irq)
    );

    // Expected line level at cycle c of a frame (c=0 is the first START cycle).
    function automatic logic frame_bit(input logic [7:0] b, input int div, input bit par, input int c);
        int k;
        k = c / div;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Bus tasks: called just after a falling edge, return after the next one.
    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
        s_ce = 1'b1; s_we = 1'b1; s_addr = {28'd0, a, 2'b00}; s_wdata = d; s_addr_sel = sel;
        @(negedge clk);
        s_ce = 1'b0; s_we = 1'b0; s_addr_sel = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        s_ce = 1'b1; s_we = 1'b0; s_addr = {28'd0, a, 2'b00};
        @(negedge clk);
        s_ce = 1'b0;
        d = s_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", txd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++; if (s_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", s_rdata); end
        rst = 1'b0;
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_status got=%h want=4", d); end
        rd(A_BAUD, d);
        total++; if (d !== 32'd434) begin bad++; $display("FAIL reset_baud got=%0d want=434", d); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
        rd(A_TX, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h want=0", d); end
    endtask

    task automatic test_single_frame;
        logic [31:0] d;
        logic e;
        wr(A_BAUD, 32'd4, 4'b0011);
        wr(A_CTRL, 32'd1, 4'b0001);
        wr(A_TX, 32'hA5, 4'b0001);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL a5_pre_start got=%b want=1", txd); end
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge clk);
            e = frame_bit(8'hA5, 4, 1'b0, c);
            total++; if (txd !== e) begin bad++; $display("FAIL a5_frame cycle=%0d got=%b want=%b", c, txd, e); end
        end
        @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL a5_idle got=%b want=1", txd); end
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL a5_status got=%h want=4", d); end
    endtask

    task automatic test_random_frames;
        logic [7:0] b;
        int dw, de;
        logic e;
        for (int i = 0; i < 6; i++) begin
            dw = (i == 0) ? 0 : int'($urandom_range(1, 5));
            de = (dw == 0) ? 1 : dw;
            b  = 8'($urandom);
            wr(A_BAUD, 32'(dw), 4'b0011);
            wr(A_TX, {24'd0, b}, 4'b0001);
            @(negedge clk);
            for (int c = 0; c < 10 * de; c++) begin
                if (c != 0) @(negedge clk);
                e = frame_bit(b, de, 1'b0, c);
                total++; if (txd !== e) begin bad++; $display("FAIL rand_frame b=%h div=%0d cycle=%0d got=%b want=%b", b, de, c, txd, e); end
            end
            @(negedge clk);
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL rand_idle got=%b want=1", txd); end
        end
    endtask

    task automatic test_baud_midframe;
        logic [7:0] b1, b2;
        logic e;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wr(A_BAUD, 32'd3, 4'b0011);
        wr(A_TX, {24'd0, b1}, 4'b0001);
        @(negedge clk);
        fork
            begin
                for (int c = 0; c < 30; c++) begin
                    if (c != 0) @(negedge clk);
                    e = frame_bit(b1, 3, 1'b0, c);
                    total++; if (txd !== e) begin bad++; $display("FAIL mid_baud_old cycle=%0d got=%b want=%b", c, txd, e); end
                end
            end
            begin
                repeat (6) @(negedge clk);
                wr(A_BAUD, 32'd5, 4'b0011);
            end
        join
        @(negedge clk);
        wr(A_TX, {24'd0, b2}, 4'b0001);
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            if (c != 0) @(negedge clk);
            e = frame_bit(b2, 5, 1'b0, c);
            total++; if (txd !== e) begin bad++; $display("FAIL mid_baud_new cycle=%0d got=%b want=%b", c, txd, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] d;
        logic e;
        wr(A_CTRL, 32'd0, 4'b0001);
        wr(A_BAUD, 32'd2, 4'b0011);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            wr(A_TX, {24'd0, b}, 4'b0001);
            if (q.size() < 8) q.push_back(b);
        end
        rd(A_ST, d);
        total++; if (d !== 32'h080A) begin bad++; $display("FAIL ovf_status got=%h want=080a", d); end
        wr(A_ST, 32'h8, 4'b0001);
        rd(A_ST, d);
        total++; if (d !== 32'h0802) begin bad++; $display("FAIL ovf_clear got=%h want=0802", d); end
        // Enable, then push on the very cycle the first byte is popped.
        b = 8'($urandom);
        wr(A_CTRL, 32'd1, 4'b0001);
        wr(A_TX, {24'd0, b}, 4'b0001);
        q.push_back(b);
        fork
            begin
                for (int f = 0; f < 9; f++) begin
                    if (f != 0) @(negedge clk);
                    for (int c = 0; c < 20; c++) begin
                        if (c != 0) @(negedge clk);
                        e = frame_bit(q[f], 2, 1'b0, c);
                        total++; if (txd !== e) begin bad++; $display("FAIL full_b2b frame=%0d cycle=%0d got=%b want=%b", f, c, txd, e); end
                    end
                end
            end
            begin
                logic [31:0] s;
                rd(A_ST, s);
                total++; if (s !== 32'h0803) begin bad++; $display("FAIL push_pop_full got=%h want=0803", s); end
            end
        join
        @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL full_b2b_idle got=%b want=1", txd); end
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL full_b2b_status got=%h want=4", d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b[3];
        logic e;
        wr(A_CTRL, 32'd2, 4'b0001);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_empty got=%b want=1", irq); end
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            wr(A_TX, {24'd0, b[i]}, 4'b0001);
        end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_nonempty got=%b want=0", irq); end
        wr(A_BAUD, 32'd2, 4'b0011);
        wr(A_CTRL, 32'd3, 4'b0001);
        @(negedge clk);
        for (int c = 0; c < 60; c++) begin
            if (c != 0) @(negedge clk);
            e = frame_bit(b[c / 20], 2, 1'b0, c % 20);
            total++; if (txd !== e) begin bad++; $display("FAIL b2b cycle=%0d got=%b want=%b", c, txd, e); end
        end
        @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", txd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL b2b_irq got=%b want=1", irq); end
    endtask

    task automatic test_en_clear;
        logic [7:0] b1, b2;
        logic [31:0] d;
        logic e;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wr(A_CTRL, 32'd0, 4'b0001);
        wr(A_BAUD, 32'd3, 4'b0011);
        wr(A_TX, {24'd0, b1}, 4'b0001);
        wr(A_TX, {24'd0, b2}, 4'b0001);
        wr(A_CTRL, 32'd1, 4'b0001);
        @(negedge clk);
        fork
            begin
                for (int c = 0; c < 30; c++) begin
                    if (c != 0) @(negedge clk);
                    e = frame_bit(b1, 3, 1'b0, c);
                    total++; if (txd !== e) begin bad++; $display("FAIL en_clear_frame cycle=%0d got=%b want=%b", c, txd, e); end
                end
            end
            begin
                repeat (4) @(negedge clk);
                wr(A_CTRL, 32'd0, 4'b0001);
            end
        join
        repeat (10) begin
            @(negedge clk);
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL en_clear_hold got=%b want=1", txd); end
        end
        rd(A_ST, d);
        total++; if (d !== 32'h0100) begin bad++; $display("FAIL en_clear_status got=%h want=0100", d); end
        // b2 stays queued for the reset test
        wr(A_BAUD, 32'd4, 4'b0011);
        wr(A_TX, 32'h5A, 4'b0001);
        wr(A_CTRL, 32'd1, 4'b0001);
        @(negedge clk);
        repeat (16) @(negedge clk);
        total++; if (txd !== b2[3]) begin bad++; $display("FAIL pre_reset_bit3 got=%b want=%b", txd, b2[3]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL midframe_reset_txd got=%b want=1", txd); end
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL midframe_reset_status got=%h want=4", d); end
        rd(A_BAUD, d);
        total++; if (d !== 32'd434) begin bad++; $display("FAIL midframe_reset_baud got=%0d want=434", d); end
    endtask

    task automatic test_ctrl_readback;
        logic [31:0] d;
        wr(A_CTRL, 32'h7, 4'b0001);
        rd(A_CTRL, d);
`ifdef UART_TX_PARITY_EN
        total++; if (d !== 32'h7) begin bad++; $display("FAIL ctrl_readback got=%h want=7", d); end
`else
        total++; if (d !== 32'h3) begin bad++; $display("FAIL ctrl_readback got=%h want=3", d); end
`endif
        wr(A_CTRL, 32'h0, 4'b0001);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] b;
        int dv;
        logic e;
        wr(A_CTRL, 32'h5, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            b  = (i == 0) ? 8'h07 : 8'($urandom);
            dv = int'($urandom_range(1, 4));
            wr(A_BAUD, 32'(dv), 4'b0011);
            wr(A_TX, {24'd0, b}, 4'b0001);
            @(negedge clk);
            for (int c = 0; c < 11 * dv; c++) begin
                if (c != 0) @(negedge clk);
                e = frame_bit(b, dv, 1'b1, c);
                total++; if (txd !== e) begin bad++; $display("FAIL parity b=%h cycle=%0d got=%b want=%b", b, c, txd, e); end
            end
            @(negedge clk);
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL parity_idle got=%b want=1", txd); end
        end
        wr(A_CTRL, 32'h0, 4'b0001);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_random_frames();
        test_baud_midframe();
        test_overflow();
        test_back_to_back();
        test_ctrl_readback();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_en_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
